// File: rtl/fixed_linear_bwd_pkg.sv
// Shared types and sizing helpers for the fixed-point linear backward datapath.
package fixed_linear_bwd_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Accumulator width that holds a full-precision sum over `rows` elements.
  function automatic int unsigned acc_width(input int unsigned prec, input int unsigned rows);
    return prec + $clog2(rows);
  endfunction

  // Counter width that stays at least one bit for a depth of one.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fixed_cast.sv
// Signed fixed-point narrowing: floor on right shift, zero pad on left shift, then saturate.
module fixed_cast #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned IN_FRAC   = 3,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned OUT_FRAC  = 3
) (
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [OUT_WIDTH-1:0] data_out_c
);

  localparam int unsigned L_SHIFT = (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int unsigned R_SHIFT = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  localparam int unsigned EXT_W   = IN_WIDTH + L_SHIFT;
  localparam int unsigned CMP_W   = (EXT_W > OUT_WIDTH) ? EXT_W : OUT_WIDTH;

  logic signed [CMP_W-1:0] shifted;
  logic signed [CMP_W-1:0] max_v;
  logic signed [CMP_W-1:0] min_v;

  // Compare in a width wide enough for both the shifted input and the output range.
  always_comb begin
    shifted = CMP_W'($signed(data_in));
    shifted = (shifted <<< L_SHIFT) >>> R_SHIFT;
    max_v   = CMP_W'($signed({1'b0, {(OUT_WIDTH-1){1'b1}}}));
    min_v   = CMP_W'($signed({1'b1, {(OUT_WIDTH-1){1'b0}}}));
    if (shifted > max_v) begin
      data_out_c = max_v[OUT_WIDTH-1:0];
    end else if (shifted < min_v) begin
      data_out_c = min_v[OUT_WIDTH-1:0];
    end else begin
      data_out_c = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_column_sum.sv
// Combinational signed sum of ROWS elements of one column lane, full precision.
module fixed_column_sum #(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned SUM_W    = IN_WIDTH + $clog2(ROWS)
) (
  input  logic [IN_WIDTH-1:0] data_in [ROWS],
  output logic [SUM_W-1:0]    sum_c
);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      sum_c = sum_c + SUM_W'($signed(data_in[i]));
    end
  end

endmodule

// File: rtl/fixed_linear_bias_grad.sv
// Bias gradient: reduces streamed dY blocks over rows into per-column sums, then drains
// them as P0-wide beats.
module fixed_linear_bias_grad
  import fixed_linear_bwd_pkg::*;
#(
  parameter int unsigned DATA_IN_0_PRECISION_0       = 16,
  parameter int unsigned DATA_IN_0_PRECISION_1       = 3,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 20,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_1 = 20,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1 = 4,
  parameter int unsigned DATA_OUT_0_PRECISION_0      = 16,
  parameter int unsigned DATA_OUT_0_PRECISION_1      = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int unsigned W           = DATA_IN_0_PRECISION_0;
  localparam int unsigned P0          = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int unsigned P1          = DATA_IN_0_PARALLELISM_DIM_1;
  localparam int unsigned DEPTH_DIM_0 = DATA_IN_0_TENSOR_SIZE_DIM_0 / P0;
  localparam int unsigned DEPTH_DIM_1 = DATA_IN_0_TENSOR_SIZE_DIM_1 / P1;
  localparam int unsigned ACC_WIDTH   = acc_width(W, DATA_IN_0_TENSOR_SIZE_DIM_1);
  localparam int unsigned SUM_W       = W + $clog2(P1);
  localparam int unsigned COL_W       = cnt_width(DEPTH_DIM_0);
  localparam int unsigned ROW_W       = cnt_width(DEPTH_DIM_1);

  state_t state_q, state_d;

  logic [COL_W-1:0]     col_cnt;
  logic [ROW_W-1:0]     row_cnt;
  logic [COL_W-1:0]     drain_ptr;
  logic [ACC_WIDTH-1:0] acc [DEPTH_DIM_0][P0];
  logic [SUM_W-1:0]     lane_sum [P0];

  logic in_hs, out_hs, last_col, last_row, last_drain;

  assign in_hs      = data_in_0_valid && (state_q == ACCUM);
  assign out_hs     = data_out_0_ready && (state_q == DRAIN);
  assign last_col   = (col_cnt == COL_W'(DEPTH_DIM_0 - 1));
  assign last_row   = (row_cnt == ROW_W'(DEPTH_DIM_1 - 1));
  assign last_drain = (drain_ptr == COL_W'(DEPTH_DIM_0 - 1));

  always_comb begin
    state_d          = state_q;
    data_in_0_ready  = 1'b0;
    data_out_0_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        data_in_0_ready = 1'b1;
        if (in_hs && last_col && last_row) state_d = DRAIN;
      end
      DRAIN: begin
        data_out_0_valid = 1'b1;
        if (out_hs && last_drain) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Per lane: gather the P1 rows of column i0, reduce them, and narrow the drain output.
  for (genvar g0 = 0; g0 < int'(P0); g0++) begin : g_lane
    logic [W-1:0] rows [P1];
    for (genvar g1 = 0; g1 < int'(P1); g1++) begin : g_row
      assign rows[g1] = data_in_0[g1*P0 + g0];
    end

    fixed_column_sum #(
      .IN_WIDTH(W),
      .ROWS    (P1),
      .SUM_W   (SUM_W)
    ) u_sum (
      .data_in(rows),
      .sum_c  (lane_sum[g0])
    );

    fixed_cast #(
      .IN_WIDTH (ACC_WIDTH),
      .IN_FRAC  (DATA_IN_0_PRECISION_1),
      .OUT_WIDTH(DATA_OUT_0_PRECISION_0),
      .OUT_FRAC (DATA_OUT_0_PRECISION_1)
    ) u_cast (
      .data_in   (acc[drain_ptr][g0]),
      .data_out_c(data_out_0[g0])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      col_cnt   <= '0;
      row_cnt   <= '0;
      drain_ptr <= '0;
      for (int c = 0; c < int'(DEPTH_DIM_0); c++) begin
        for (int i = 0; i < int'(P0); i++) acc[c][i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        for (int i = 0; i < int'(P0); i++) begin
          acc[col_cnt][i] <= acc[col_cnt][i] + ACC_WIDTH'($signed(lane_sum[i]));
        end
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      // Clearing on drain leaves the bank zeroed for the next batch.
      if (out_hs) begin
        for (int i = 0; i < int'(P0); i++) acc[drain_ptr][i] <= '0;
        drain_ptr <= last_drain ? '0 : drain_ptr + 1'b1;
      end
    end
  end

endmodule
